// File: rtl/ray_job_sched.sv
// Ray batch sequencer for the SDRAM bridge: fetch a 480-bit ray record, hand it to
// the intersector, collect its 64-bit result and write it back, one ray at a time.
module ray_job_sched #(
  parameter int          NUM_RAYS_W = 16,
  parameter logic [31:0] RD_BASE    = 32'h0000_0000,
  parameter logic [31:0] WR_BASE    = 32'h0010_0000,
  parameter logic [31:0] RAY_STRIDE = 32'd60,
  parameter logic [31:0] RES_STRIDE = 32'd8,
  parameter int          TMO_CYC    = 65535
) (
  input  logic                  sdr_clk,
  input  logic                  sdr_reset_n,
  input  logic                  start,
  input  logic [NUM_RAYS_W-1:0] num_rays,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [NUM_RAYS_W-1:0] rays_done,
  output logic                  sdr_readstart,
  output logic [31:0]           sdr_readaddr,
  input  logic [479:0]          sdr_readdata,
  input  logic                  sdr_readend,
  output logic                  ix_valid,
  input  logic                  ix_ready,
  output logic [479:0]          ix_ray,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [63:0]           res_data,
  output logic                  sdr_writestart,
  output logic [31:0]           sdr_writeaddr,
  output logic [63:0]           sdr_writedata,
  input  logic                  sdr_writeend
);

  localparam int TW = $clog2(TMO_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_ISSUE, S_RES_WAIT,
    S_WR_REQ, S_WR_WAIT, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t                state_q;
  logic                  rd_end_q, wr_end_q;
  logic [TW-1:0]         tmo_q;
  logic [NUM_RAYS_W-1:0] num_q, cnt_q;
  logic [31:0]           rd_addr_q, wr_addr_q;
  logic                  busy_q, done_q, err_q, rs_q, ws_q, ixv_q, rr_q;
  logic [479:0]          ray_q;
  logic [63:0]           wd_q;
  logic                  rd_rise, wr_rise, tmo_hit;

  // Only a rising end flag counts; a level left high by an earlier transfer is ignored.
  assign rd_rise = sdr_readend  & ~rd_end_q;
  assign wr_rise = sdr_writeend & ~wr_end_q;
  assign tmo_hit = (32'(tmo_q) + 32'd1) >= 32'(TMO_CYC);

  always_ff @(posedge sdr_clk or negedge sdr_reset_n) begin
    if (!sdr_reset_n) begin
      state_q   <= S_IDLE;
      rd_end_q  <= 1'b0;
      wr_end_q  <= 1'b0;
      tmo_q     <= '0;
      num_q     <= '0;
      cnt_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rs_q      <= 1'b0;
      ws_q      <= 1'b0;
      ixv_q     <= 1'b0;
      rr_q      <= 1'b0;
      ray_q     <= '0;
      wd_q      <= '0;
    end else begin
      rd_end_q <= sdr_readend;
      wr_end_q <= sdr_writeend;
      done_q   <= 1'b0;
      rs_q     <= 1'b0;
      ws_q     <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          err_q     <= 1'b0;
          cnt_q     <= '0;
          num_q     <= num_rays;
          rd_addr_q <= RD_BASE;
          wr_addr_q <= WR_BASE;
          if (num_rays == '0) state_q <= S_DONE;
          else begin
            busy_q  <= 1'b1;
            rs_q    <= 1'b1;
            state_q <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          tmo_q   <= '0;
          state_q <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (rd_rise) begin
            ray_q   <= sdr_readdata;
            ixv_q   <= 1'b1;
            state_q <= S_ISSUE;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else if (tmo_q != '1) tmo_q <= tmo_q + 1'b1;
        end
        S_ISSUE: if (ix_ready) begin
          ixv_q   <= 1'b0;
          rr_q    <= 1'b1;
          state_q <= S_RES_WAIT;
        end
        S_RES_WAIT: if (res_valid) begin
          wd_q    <= res_data;
          rr_q    <= 1'b0;
          ws_q    <= 1'b1;
          state_q <= S_WR_REQ;
        end
        S_WR_REQ: begin
          tmo_q   <= '0;
          state_q <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (wr_rise) begin
            cnt_q     <= cnt_q + 1'b1;
            rd_addr_q <= rd_addr_q + RAY_STRIDE;
            wr_addr_q <= wr_addr_q + RES_STRIDE;
            state_q   <= S_NEXT;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else if (tmo_q != '1) tmo_q <= tmo_q + 1'b1;
        end
        S_NEXT: begin
          if (cnt_q == num_q) state_q <= S_DONE;
          else begin
            rs_q    <= 1'b1;
            state_q <= S_RD_REQ;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_ERR: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = err_q;
  assign rays_done      = cnt_q;
  assign sdr_readstart  = rs_q;
  assign sdr_readaddr   = rd_addr_q;
  assign ix_valid       = ixv_q;
  assign ix_ray         = ray_q;
  assign res_ready      = rr_q;
  assign sdr_writestart = ws_q;
  assign sdr_writeaddr  = wr_addr_q;
  assign sdr_writedata  = wd_q;

endmodule

// File: tb/tb_ray_job_sched.sv
// Directed bench for ray_job_sched: bridge/intersector responders plus a scoreboard of
// expected read/write addresses, ray records and write data.
module tb_ray_job_sched;
  localparam int NW = 16;

  logic           sdr_clk = 1'b0, sdr_reset_n = 1'b0, start = 1'b0;
  logic [NW-1:0]  num_rays = '0;
  logic           busy, done, error;
  logic [NW-1:0]  rays_done;
  logic           sdr_readstart;
  logic [31:0]    sdr_readaddr;
  logic [479:0]   sdr_readdata = '0;
  logic           sdr_readend = 1'b0;
  logic           ix_valid;
  logic           ix_ready = 1'b0;
  logic [479:0]   ix_ray;
  logic           res_valid = 1'b0;
  logic           res_ready;
  logic [63:0]    res_data = '0;
  logic           sdr_writestart;
  logic [31:0]    sdr_writeaddr;
  logic [63:0]    sdr_writedata;
  logic           sdr_writeend = 1'b0;

  ray_job_sched #(.TMO_CYC(16)) dut (
    .sdr_clk(sdr_clk), .sdr_reset_n(sdr_reset_n), .start(start), .num_rays(num_rays),
    .busy(busy), .done(done), .error(error), .rays_done(rays_done),
    .sdr_readstart(sdr_readstart), .sdr_readaddr(sdr_readaddr),
    .sdr_readdata(sdr_readdata), .sdr_readend(sdr_readend),
    .ix_valid(ix_valid), .ix_ready(ix_ready), .ix_ray(ix_ray),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .sdr_writestart(sdr_writestart), .sdr_writeaddr(sdr_writeaddr),
    .sdr_writedata(sdr_writedata), .sdr_writeend(sdr_writeend)
  );

  always #5 sdr_clk = ~sdr_clk;

  int chk = 0, errs = 0, cyc = 0;
  always @(posedge sdr_clk) cyc <= cyc + 1;

  // responder knobs (written by the stimulus only)
  int rd_dly = 5, rd_drop = 1, wr_dly = 5, ix_stall = 0, hang_at = -1;
  bit rd_hold_hi = 1'b0;
  logic [63:0] res_base = 64'h1000;

  // responder / monitor state
  int rd_t, wr_t, rd_starts = 0, wr_starts = 0, ix_wait = 0, res_k = 0, done_cnt = 0;
  int hang_cyc = 0, err_cyc = 0;
  bit rd_act = 0, wr_act = 0, rd_hang = 0, ix_unstable = 0, both_pulse = 0, err_prev = 0;
  logic [31:0]  rd_cap;
  logic [479:0] ix_cap;

  logic [31:0]  exp_rd[$], exp_wr[$];
  logic [63:0]  exp_wd[$];
  logic [479:0] exp_ray[$];

  task automatic check(input string tag, input logic [479:0] obs, input logic [479:0] exp);
    chk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [479:0] rec(input logic [31:0] a);
    logic [479:0] r;
    r = '0;
    for (int w = 0; w < 15; w++) r[w*32 +: 32] = a ^ (32'(w) << 24) ^ 32'h5A5A_0000;
    return r;
  endfunction

  // SDRAM bridge: end flag drops rd_drop cycles after a start, rises rd_dly cycles after it.
  always @(negedge sdr_clk) begin
    if (sdr_readstart) begin
      rd_t = 0; rd_act = 1; rd_cap = sdr_readaddr;
      rd_hang = (rd_starts == hang_at);
      if (rd_hang) hang_cyc = cyc;
      rd_starts++;
    end else if (rd_act) begin
      rd_t++;
      if (rd_t == rd_drop) sdr_readend = 1'b0;
      if (rd_t == rd_dly) begin
        rd_act = 0;
        if (!rd_hang) begin sdr_readdata = rec(rd_cap); sdr_readend = 1'b1; end
      end
    end else if (rd_hold_hi) begin
      sdr_readend = 1'b1; sdr_readdata = '1;
    end
    if (sdr_writestart) begin
      wr_t = 0; wr_act = 1; wr_starts++;
    end else if (wr_act) begin
      wr_t++;
      if (wr_t == 1) sdr_writeend = 1'b0;
      if (wr_t == wr_dly) begin wr_act = 0; sdr_writeend = 1'b1; end
    end
  end

  // intersector: accepts after ix_stall cycles, returns result immediately
  always @(negedge sdr_clk) begin
    if (ix_valid && !ix_ready) begin
      ix_wait++;
      if (ix_wait == 1) ix_cap = ix_ray;
      else if (ix_ray !== ix_cap) ix_unstable = 1;
      if (ix_wait > ix_stall) begin
        ix_ready = 1'b1;
        check("ix_pending", 480'(exp_ray.size() > 0), 480'(1));
        if (exp_ray.size() > 0) check("ix_ray", ix_ray, exp_ray.pop_front());
      end
    end else begin
      ix_ready = 1'b0; ix_wait = 0;
    end
    if (res_valid) res_k++;
    if (!busy) res_k = 0;
    res_valid = res_ready;
    res_data  = res_base + 64'(res_k);
  end

  // scoreboard side: every request pulse pops its expected address/data
  always @(negedge sdr_clk) begin
    if (sdr_readstart && sdr_writestart) both_pulse = 1;
    if (sdr_readstart) begin
      check("rd_pending", 480'(exp_rd.size() > 0), 480'(1));
      if (exp_rd.size() > 0) check("rd_addr", 480'(sdr_readaddr), 480'(exp_rd.pop_front()));
    end
    if (sdr_writestart) begin
      check("wr_pending", 480'(exp_wr.size() > 0), 480'(1));
      if (exp_wr.size() > 0) check("wr_addr", 480'(sdr_writeaddr), 480'(exp_wr.pop_front()));
      if (exp_wd.size() > 0) check("wr_data", 480'(sdr_writedata), 480'(exp_wd.pop_front()));
    end
    if (done) done_cnt++;
    if (error && !err_prev) err_cyc = cyc;
    err_prev = error;
  end

  task automatic push_batch(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] ra;
      ra = 32'h0 + 32'(i) * 32'd60;
      exp_rd.push_back(ra);
      exp_ray.push_back(rec(ra));
      exp_wr.push_back(32'h0010_0000 + 32'(i) * 32'd8);
      exp_wd.push_back(res_base + 64'(i));
    end
  endtask

  task automatic flush_q();
    exp_rd.delete(); exp_wr.delete(); exp_wd.delete(); exp_ray.delete();
  endtask

  task automatic do_start(input int n);
    @(negedge sdr_clk);
    start = 1'b1; num_rays = NW'(n);
    @(negedge sdr_clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int c;
    c = 0;
    while (busy && c < maxc) begin @(negedge sdr_clk); c++; end
    check(tag, 480'(busy), 480'(0));
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_busy"},   480'(busy), 480'(0));
    check({pfx, "_done"},   480'(done), 480'(0));
    check({pfx, "_error"},  480'(error), 480'(0));
    check({pfx, "_rays"},   480'(rays_done), 480'(0));
    check({pfx, "_pulses"}, 480'({sdr_readstart, sdr_writestart, ix_valid, res_ready}), 480'(0));
    check({pfx, "_addrs"},  480'({sdr_readaddr, sdr_writeaddr}), 480'(0));
    check({pfx, "_wdata"},  480'(sdr_writedata), 480'(0));
    check({pfx, "_ixray"},  ix_ray, 480'(0));
  endtask

  initial begin
    int d0, r0, w0, c;
    repeat (3) @(negedge sdr_clk);
    check_idle_outputs("rst");
    sdr_reset_n = 1'b1;
    @(negedge sdr_clk);

    // 1: three-ray batch, 5-cycle bridge
    d0 = done_cnt; r0 = rd_starts;
    push_batch(3);
    do_start(3);
    check("t1_busy", 480'(busy), 480'(1));
    wait_idle(300, "t1_finish");
    @(negedge sdr_clk);
    check("t1_rays_done", 480'(rays_done), 480'(3));
    check("t1_done_cnt", 480'(done_cnt), 480'(d0 + 1));
    check("t1_rd_starts", 480'(rd_starts), 480'(r0 + 3));
    check("t1_q_empty", 480'(exp_rd.size() + exp_wr.size() + exp_wd.size() + exp_ray.size()), 480'(0));

    // 2: empty batch
    d0 = done_cnt; r0 = rd_starts; w0 = wr_starts;
    @(negedge sdr_clk);
    start = 1'b1; num_rays = '0;
    @(negedge sdr_clk);
    start = 1'b0;
    check("t2_done_c1", 480'(done), 480'(0));
    @(negedge sdr_clk);
    check("t2_done_c2", 480'(done), 480'(1));
    check("t2_busy", 480'(busy), 480'(0));
    @(negedge sdr_clk);
    check("t2_done_c3", 480'(done), 480'(0));
    repeat (3) @(negedge sdr_clk);
    check("t2_no_starts", 480'({rd_starts - r0, wr_starts - w0}), 480'(0));
    check("t2_done_cnt", 480'(done_cnt), 480'(d0 + 1));

    // 3: intersector stalls 50 cycles
    ix_stall = 50; res_base = 64'hBEEFD00DDEADBEEF; ix_unstable = 0;
    push_batch(1);
    do_start(1);
    wait_idle(300, "t3_finish");
    @(negedge sdr_clk);
    check("t3_ix_stable", 480'(ix_unstable), 480'(0));
    check("t3_rays_done", 480'(rays_done), 480'(1));
    check("t3_wdata", 480'(sdr_writedata), 480'(64'hBEEFD00DDEADBEEF));
    ix_stall = 0; res_base = 64'h1000;

    // 4: bridge never completes the read of ray 1
    d0 = done_cnt;
    hang_at = rd_starts + 1;
    push_batch(3);
    do_start(3);
    c = 0;
    while (!error && c < 200) begin @(negedge sdr_clk); c++; end
    repeat (2) @(negedge sdr_clk);
    check("t4_error", 480'(error), 480'(1));
    check("t4_tmo_cycles", 480'(err_cyc - hang_cyc), 480'(17));
    check("t4_busy", 480'(busy), 480'(0));
    check("t4_rays_done", 480'(rays_done), 480'(1));
    check("t4_no_done", 480'(done_cnt), 480'(d0));
    repeat (3) @(negedge sdr_clk);
    check("t4_sticky", 480'(error), 480'(1));
    flush_q(); hang_at = -1;
    push_batch(1);
    do_start(1);
    check("t4_err_cleared", 480'(error), 480'(0));
    wait_idle(200, "t4_recover");
    check("t4_recover_rays", 480'(rays_done), 480'(1));

    // 5: readend already high before the request
    rd_hold_hi = 1'b1;
    repeat (4) @(negedge sdr_clk);
    rd_hold_hi = 1'b0; rd_drop = 3;
    push_batch(1);
    do_start(1);
    repeat (2) @(negedge sdr_clk);
    check("t5_no_early_issue", 480'(ix_valid), 480'(0));
    wait_idle(200, "t5_finish");
    check("t5_rays_done", 480'(rays_done), 480'(1));
    rd_drop = 1;

    // 6: reset while waiting on a write, then a clean batch with a stray start
    wr_dly = 12; w0 = wr_starts;
    push_batch(2);
    do_start(2);
    c = 0;
    while (wr_starts == w0 && c < 200) begin @(negedge sdr_clk); c++; end
    check("t6_reached_wr", 480'(wr_starts), 480'(w0 + 1));
    repeat (3) @(negedge sdr_clk);
    sdr_reset_n = 1'b0;
    @(negedge sdr_clk);
    check_idle_outputs("t6_rst");
    flush_q();
    sdr_reset_n = 1'b1;
    @(negedge sdr_clk);
    wr_dly = 5; d0 = done_cnt; r0 = rd_starts;
    push_batch(1);
    do_start(1);
    do_start(7);
    wait_idle(300, "t6_finish");
    @(negedge sdr_clk);
    check("t6_rays_done", 480'(rays_done), 480'(1));
    check("t6_done_cnt", 480'(done_cnt), 480'(d0 + 1));
    check("t6_rd_starts", 480'(rd_starts), 480'(r0 + 1));
    check("t6_q_empty", 480'(exp_rd.size() + exp_wr.size() + exp_wd.size() + exp_ray.size()), 480'(0));
    check("no_dual_pulse", 480'(both_pulse), 480'(0));

    $display("Simulation finished: %0d checks, %0d errors", chk, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", chk, errs);
    $fatal(1, "watchdog expired");
  end

endmodule
